vend_coin_sched: RTL
====================

# vend_coin_sched

Coin scheduler and dispense sequencer in front of the 5-state coin-accumulating vending FSM (input code 2'b01 = 5-unit coin, 2'b10 = 10-unit coin; output 2'b10 = vend, 2'b11 = vend + change). It does three things:
- Arbitrates two coin slots round-robin and serialises them into single-cycle coin codes separated by idle gaps.
- Captures the FSM's one-cycle vend indication.
- Stretches that indication into timed motor and change pulses while blocking new coins.

## Interface
- GAP_CYCLES, 2: idle (2'b00) cycles driven after every issued coin; legal range ≥1.
- DISP_CYCLES, 8: length of the vend/change pulse in cycles; legal range ≥1.
- CNT_W, 8: width of the sale counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_a  in  1  slot A (5-unit coin) request, held until ack_a.
- req_b  in  1  slot B (10-unit coin) request, held until ack_b.
- fsm_out  in  2  output of the vending FSM.
- coin  out  2  coin code to the vending FSM input.
- ack_a  out  1  one-cycle grant to slot A.
- ack_b  out  1  one-cycle grant to slot B.
- vend  out  1  dispense motor enable.
- chg  out  1  change ejector enable.
- busy  out  1  high whenever state ≠ IDLE.
- sale_cnt  out  CNT_W  completed sales, saturating.

## Operation
**States:** IDLE, ISSUE, GAP, DISP. All outputs are registered.

**IDLE**
- coin=00.
- If fsm_out==2'b10 or 2'b11: latch chg_pend=fsm_out[0] and go to DISP. This takes priority over requests.
- Else if any request: pick the winner and go to ISSUE.
- Round-robin rule: if both requests are high, grant the slot not granted last. last_grant resets to B, so A wins the first tie.

**ISSUE** (exactly 1 cycle)
- coin=01 for A or 10 for B.
- The matching ack is high for this cycle.
- last_grant updated.
- Next state: GAP.

**GAP**
- coin=00 for GAP_CYCLES cycles.
- On every GAP cycle, if fsm_out[1]==1: latch chg_pend=fsm_out[0] and go to DISP immediately, abandoning the rest of the gap.
- After the final gap cycle: go to IDLE.

**DISP**
- vend=1 and chg=chg_pend for DISP_CYCLES cycles.
- On the last cycle: increment sale_cnt, saturating at all-ones.
- Next state: IDLE. chg_pend is cleared on exit.

**Other rules**
- Requests are never acked in DISP or GAP; they stay pending.
- fsm_out==2'b01 is illegal and is ignored in every state.
- The vending FSM drops its vend code after one cycle of coin=00. Capture in GAP cycle 1 is therefore mandatory, and no fsm_out value may be missed.

## Timing
- Reset (rst=0): state=IDLE, coin=00, ack_a=ack_b=0, vend=chg=0, busy=0, sale_cnt=0, chg_pend=0, last_grant=B. Takes effect immediately, including mid-DISP or mid-GAP.
- Request latency: req sampled high in IDLE at edge N → coin and ack valid in cycle N+1 → coin=00 from N+2.
- Coin-to-coin spacing: minimum 1+GAP_CYCLES+1 cycles between consecutive ISSUE cycles.
- fsm_out reacts to an issued coin in GAP cycle 1. vend rises at the next edge.
- Simultaneous fsm_out vend code and a request in IDLE: DISP wins; the request waits.
- After DISP, IDLE lasts at least 1 cycle before the next ISSUE.

## Structure
- Shared package vend_pkg holds:
  - state enum {IDLE, ISSUE, GAP, DISP};
  - coin codes COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10;
  - FSM output codes OUT_VEND=2'b10, OUT_VEND_CHG=2'b11.
- Sub-module vend_timer: loadable down-counter with done flag. One instance is shared by GAP (load GAP_CYCLES-1) and DISP (load DISP_CYCLES-1). Its width is derived from max(GAP_CYCLES, DISP_CYCLES).

## Test plan
- **Single slot A coin.** rst released, req_a=1 held. Expect coin=01 and ack_a=1 for one cycle, then coin=00 for 2 cycles, then IDLE. Drop req_a after ack_a.
- **Simultaneous requests.** req_a=req_b=1 held. Expect the grant order A, B, A, B; coin alternates 01/10 with ISSUE cycles 4 cycles apart.
- **Vend without change.** fsm_out=10 for one cycle in GAP cycle 1. Expect vend=1 for exactly 8 cycles, chg=0 throughout, and sale_cnt 0→1.
- **Vend with change, pending request.** fsm_out=11 pulse, with req_b raised during DISP. Expect vend=chg=1 for 8 cycles and no ack_b until the cycle after return to IDLE.
- **Reset mid-dispense.** rst=0 on DISP cycle 4. Expect vend, chg, busy and sale_cnt at 0 asynchronously (before the next edge), then coin=00 and IDLE after release.
- **Counter saturation.** CNT_W=2, run 5 sales. Expect sale_cnt=3 after the third sale and to stay at 3.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and codes for the coin scheduler in front of the vending FSM.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DISP  = 2'd3
  } state_e;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_5       = 2'b01;
  localparam logic [1:0] COIN_10      = 2'b10;

  localparam logic [1:0] OUT_VEND     = 2'b10;
  localparam logic [1:0] OUT_VEND_CHG = 2'b11;

  // Bits needed to hold a down-count from n-1 to 0.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter that stops at zero; done flags the final cycle of a phase.
module vend_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/vend_coin_sched.sv
// Round-robin coin serialiser and dispense sequencer ahead of the vending FSM.
module vend_coin_sched
  import vend_pkg::*;
#(
  parameter int GAP_CYCLES  = 2,
  parameter int DISP_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [1:0]       fsm_out,
  output logic [1:0]       coin,
  output logic             ack_a,
  output logic             ack_b,
  output logic             vend,
  output logic             chg,
  output logic             busy,
  output logic [CNT_W-1:0] sale_cnt
);

  localparam int TMAX = (GAP_CYCLES > DISP_CYCLES) ? GAP_CYCLES : DISP_CYCLES;
  localparam int TW   = cnt_width(TMAX);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] DISP_LOAD = TW'(DISP_CYCLES - 1);

  state_e           state_q, state_d;
  logic             grant_b_q, grant_b_d;
  logic             last_b_q, last_b_d;
  logic             chg_pend_q, chg_pend_d;
  logic [1:0]       coin_q, coin_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             vend_q, vend_d;
  logic             chg_q, chg_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] sale_cnt_q, sale_cnt_d;

  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_dec;
  logic             tmr_done;

  vend_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    grant_b_d  = grant_b_q;
    last_b_d   = last_b_q;
    chg_pend_d = chg_pend_q;
    sale_cnt_d = sale_cnt_q;
    tmr_load   = 1'b0;
    tmr_val    = GAP_LOAD;
    tmr_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        // A vend code outranks waiting coins so it is never missed.
        if ((fsm_out == OUT_VEND) || (fsm_out == OUT_VEND_CHG)) begin
          chg_pend_d = fsm_out[0];
          state_d    = DISP;
          tmr_load   = 1'b1;
          tmr_val    = DISP_LOAD;
        end else if (req_a || req_b) begin
          grant_b_d = req_b && (!req_a || !last_b_q);
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        last_b_d = grant_b_q;
        state_d  = GAP;
        tmr_load = 1'b1;
        tmr_val  = GAP_LOAD;
      end
      GAP: begin
        if (fsm_out[1]) begin
          chg_pend_d = fsm_out[0];
          state_d    = DISP;
          tmr_load   = 1'b1;
          tmr_val    = DISP_LOAD;
        end else if (tmr_done) begin
          state_d = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DISP: begin
        if (tmr_done) begin
          state_d    = IDLE;
          chg_pend_d = 1'b0;
          if (sale_cnt_q != '1) begin
            sale_cnt_d = sale_cnt_q + 1'b1;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    coin_d  = COIN_NONE;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    if (state_d == ISSUE) begin
      coin_d  = grant_b_d ? COIN_10 : COIN_5;
      ack_a_d = !grant_b_d;
      ack_b_d = grant_b_d;
    end
    vend_d = (state_d == DISP);
    chg_d  = (state_d == DISP) && chg_pend_d;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_b_q  <= 1'b0;
      last_b_q   <= 1'b1;
      chg_pend_q <= 1'b0;
      coin_q     <= COIN_NONE;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      vend_q     <= 1'b0;
      chg_q      <= 1'b0;
      busy_q     <= 1'b0;
      sale_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_b_q  <= grant_b_d;
      last_b_q   <= last_b_d;
      chg_pend_q <= chg_pend_d;
      coin_q     <= coin_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      vend_q     <= vend_d;
      chg_q      <= chg_d;
      busy_q     <= busy_d;
      sale_cnt_q <= sale_cnt_d;
    end
  end

  assign coin     = coin_q;
  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;
  assign vend     = vend_q;
  assign chg      = chg_q;
  assign busy     = busy_q;
  assign sale_cnt = sale_cnt_q;

endmodule
